// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types for the data-memory arbiter
package dmem_arbiter_pkg;

    localparam int TAG_W = 4;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [31:0]      rv32i_word;

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        LOAD,
        LOAD_DRAIN
    } dmem_arb_state_t;

    function automatic rv32i_word word_align(input rv32i_word addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - ROB store, load-buffer and data-cache signal bundle
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic      rob_mem_write;
    rv32i_word rob_mem_address;
    rv32i_word rob_mem_wdata;
    logic [3:0] rob_mem_byte_enable;
    logic      rob_mem_resp;

    logic      ld_mem_read;
    rv32i_word ld_mem_address;
    tag_t      ld_tag;
    logic      ld_mem_resp;
    rv32i_word ld_mem_rdata;
    tag_t      ld_resp_tag;

    logic      flush;

    logic      dcache_read;
    logic      dcache_write;
    rv32i_word dcache_address;
    rv32i_word dcache_wdata;
    logic [3:0] dcache_byte_enable;
    logic      dcache_resp;
    rv32i_word dcache_rdata;

    // Arbiter side
    modport slave (
        input  rob_mem_write, rob_mem_address, rob_mem_wdata, rob_mem_byte_enable,
        output rob_mem_resp,
        input  ld_mem_read, ld_mem_address, ld_tag,
        output ld_mem_resp, ld_mem_rdata, ld_resp_tag,
        input  flush,
        output dcache_read, dcache_write, dcache_address, dcache_wdata, dcache_byte_enable,
        input  dcache_resp, dcache_rdata
    );

    // Requester / cache side
    modport master (
        output rob_mem_write, rob_mem_address, rob_mem_wdata, rob_mem_byte_enable,
        input  rob_mem_resp,
        output ld_mem_read, ld_mem_address, ld_tag,
        input  ld_mem_resp, ld_mem_rdata, ld_resp_tag,
        output flush,
        input  dcache_read, dcache_write, dcache_address, dcache_wdata, dcache_byte_enable,
        output dcache_resp, dcache_rdata
    );

endinterface

// File: rtl/dmem_perf_counter.sv
// rtl/dmem_perf_counter.sv - 32-bit wrapping event counter
module dmem_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= 32'd0;
        else if (inc)
            count <= count + 32'd1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - arbitrates ROB stores and buffered loads onto one data-cache port
// Optional perf counters enabled by DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output rv32i_word       perf_store_cnt,
    output rv32i_word       perf_load_cnt,
    output rv32i_word       perf_stall_cnt
`endif
);

    dmem_arb_state_t state, state_next;

    rv32i_word  addr_q, wdata_q;
    logic [3:0] be_q;
    tag_t       tag_q;

    rv32i_word  addr_d, wdata_d;
    logic [3:0] be_d;
    tag_t       tag_d;

    logic store_grant, load_grant;
    logic rob_resp_c, ld_resp_c;

    logic       dc_read_q, dc_write_q;
    rv32i_word  dc_addr_q, dc_wdata_q;
    logic [3:0] dc_be_q;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Flush only blocks new loads and kills an in-flight load; stores are committed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.rob_mem_write)
                    state_next = STORE;
                else if (bus.ld_mem_read && !bus.flush)
                    state_next = LOAD;
            end
            STORE: begin
                if (bus.dcache_resp)
                    state_next = IDLE;
            end
            LOAD: begin
                if (bus.dcache_resp)
                    state_next = IDLE;
                else if (bus.flush)
                    state_next = LOAD_DRAIN;
            end
            LOAD_DRAIN: begin
                if (bus.dcache_resp)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        store_grant = 1'b0;
        load_grant  = 1'b0;
        rob_resp_c  = 1'b0;
        ld_resp_c   = 1'b0;
        case (state)
            IDLE: begin
                store_grant = bus.rob_mem_write;
                load_grant  = !bus.rob_mem_write && bus.ld_mem_read && !bus.flush;
            end
            STORE:      rob_resp_c = bus.dcache_resp && !rst;
            LOAD:       ld_resp_c  = bus.dcache_resp && !bus.flush && !rst;
            LOAD_DRAIN: ;
            default:    ;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        tag_d   = tag_q;
        if (store_grant) begin
            addr_d  = bus.rob_mem_address;
            wdata_d = bus.rob_mem_wdata;
            be_d    = bus.rob_mem_byte_enable;
        end else if (load_grant) begin
            addr_d  = bus.ld_mem_address;
            tag_d   = bus.ld_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            tag_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            tag_q   <= tag_d;
        end
    end

    // Cache request is registered from the next-state view so it appears the cycle after grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            dc_read_q  <= 1'b0;
            dc_write_q <= 1'b0;
            dc_addr_q  <= '0;
            dc_wdata_q <= '0;
            dc_be_q    <= '0;
        end else begin
            dc_write_q <= (state_next == STORE);
            dc_read_q  <= (state_next == LOAD) || (state_next == LOAD_DRAIN);
            dc_addr_q  <= word_align(addr_d);
            dc_wdata_q <= (state_next == STORE) ? wdata_d : '0;
            if (state_next == STORE)
                dc_be_q <= be_d;
            else if ((state_next == LOAD) || (state_next == LOAD_DRAIN))
                dc_be_q <= 4'hF;
            else
                dc_be_q <= 4'h0;
        end
    end

    assign bus.dcache_read        = dc_read_q;
    assign bus.dcache_write       = dc_write_q;
    assign bus.dcache_address     = dc_addr_q;
    assign bus.dcache_wdata       = dc_wdata_q;
    assign bus.dcache_byte_enable = dc_be_q;

    assign bus.rob_mem_resp = rob_resp_c;
    assign bus.ld_mem_resp  = ld_resp_c;
    assign bus.ld_mem_rdata = ld_resp_c ? bus.dcache_rdata : '0;
    assign bus.ld_resp_tag  = ld_resp_c ? tag_q : '0;

`ifdef DMEM_ARB_PERF_EN
    logic stall_inc;
    assign stall_inc = bus.ld_mem_read && !load_grant && !ld_resp_c;

    dmem_perf_counter u_store_cnt (.clk(clk), .rst(rst), .inc(rob_resp_c), .count(perf_store_cnt));
    dmem_perf_counter u_load_cnt  (.clk(clk), .rst(rst), .inc(ld_resp_c),  .count(perf_load_cnt));
    dmem_perf_counter u_stall_cnt (.clk(clk), .rst(rst), .inc(stall_inc),  .count(perf_stall_cnt));
`endif

endmodule
